// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM burst reader/writer pair.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } sdram_state_e;

  localparam int BC_W          = 8;
  localparam int DEF_BURST_LEN = 16;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous show-ahead FIFO: data_o always presents the head word.
module sdram_wr_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_pop  = pop_i & (count_q != {(AW+1){1'b0}});
  assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and count registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/sdram_writer.sv
// Streams Avalon-ST words into SDRAM as Avalon-MM write bursts of up to BURST_LEN beats.
module sdram_writer
  import sdram_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 29,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [23:0]         length_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic [DATA_W-1:0]   st_data_i,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  output logic [ADDR_W-1:0]   sdram_address_o,
  output logic [BC_W-1:0]     sdram_burstcount_o,
  output logic [DATA_W-1:0]   sdram_writedata_o,
  output logic [DATA_W/8-1:0] sdram_byteenable_o,
  output logic                sdram_write_o,
  input  logic                sdram_waitrequest_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  sdram_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, address_q, address_d;
  logic [23:0]       remaining_q, remaining_d, length_q, length_d, accepted_q, accepted_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d, burstcount_q, burstcount_d, beats_s;
  logic              busy_q, busy_d, done_q, done_d, ready_q, ready_d, write_q, write_d;
  logic [CNT_W-1:0]  fifo_count_s, count_d_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_full_s, fifo_empty_s, push_s, pop_s;

  assign pop_s  = write_q & ~sdram_waitrequest_i & ~fifo_empty_s;
  assign push_s = st_valid_i & ready_q & (~fifo_full_s | pop_s);

  sdram_wr_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (st_data_i),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Burst sequencing and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    length_d     = length_q;
    accepted_d   = push_s ? accepted_q + 24'd1 : accepted_q;
    beat_cnt_d   = beat_cnt_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    write_d      = write_q;
    count_d_s    = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    if (remaining_q < 24'(BURST_LEN)) beats_s = remaining_q[BC_W-1:0];
    else                              beats_s = BC_W'(BURST_LEN);

    case (state_q)
      ST_IDLE: begin
        write_d = 1'b0;
        if (start_i) begin
          if (length_i != 24'd0) begin
            state_d     = ST_FILL;
            addr_d      = base_addr_i;
            remaining_d = length_i;
            length_d    = length_i;
            accepted_d  = 24'd0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (int'(fifo_count_s) >= int'(beats_s)) begin
          state_d      = ST_BURST;
          address_d    = addr_q;
          burstcount_d = beats_s;
          beat_cnt_d   = {BC_W{1'b0}};
          write_d      = 1'b1;
        end else begin
          write_d = 1'b0;
        end
      end
      ST_BURST: begin
        if (pop_s) begin
          if (beat_cnt_q + 8'd1 == burstcount_q) begin
            addr_d      = addr_q + ADDR_W'(burstcount_q);
            remaining_d = remaining_q - 24'(burstcount_q);
            write_d     = 1'b0;
            state_d     = (remaining_d != 24'd0) ? ST_FILL : ST_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            write_d    = (count_d_s != {CNT_W{1'b0}});
          end
        end else if (write_q) begin
          write_d = 1'b1;
        end else begin
          write_d = (count_d_s != {CNT_W{1'b0}});
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
      end
    endcase

    busy_d  = (state_d == ST_FILL) || (state_d == ST_BURST);
    done_d  = (state_d == ST_DONE);
    ready_d = busy_d & (count_d_s < DEPTH_CNT) & (accepted_d < length_d);
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      remaining_q  <= 24'd0;
      length_q     <= 24'd0;
      accepted_q   <= 24'd0;
      beat_cnt_q   <= {BC_W{1'b0}};
      address_q    <= {ADDR_W{1'b0}};
      burstcount_q <= {BC_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      length_q     <= length_d;
      accepted_q   <= accepted_d;
      beat_cnt_q   <= beat_cnt_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      write_q      <= write_d;
    end
  end

  // Data and enables only show while a write is presented, keeping idle outputs at zero.
  assign sdram_writedata_o  = write_q ? fifo_head_s : {DATA_W{1'b0}};
  assign sdram_byteenable_o = write_q ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};
  assign sdram_write_o      = write_q;
  assign sdram_address_o    = address_q;
  assign sdram_burstcount_o = burstcount_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign st_ready_o         = ready_q;

endmodule

// File: tb/tb_sdram_writer.sv
// Directed bench for sdram_writer: checks bursts, ordering, stalls, wrap, zero length and reset.
module tb_sdram_writer;

  localparam int DW = 64;
  localparam int AW = 29;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [23:0]   length_i;
  logic          busy_o, done_o;
  logic [DW-1:0] st_data_i;
  logic          st_valid_i, st_ready_o;
  logic [AW-1:0] sdram_address_o;
  logic [7:0]    sdram_burstcount_o;
  logic [DW-1:0] sdram_writedata_o;
  logic [7:0]    sdram_byteenable_o;
  logic          sdram_write_o, sdram_waitrequest_i;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  sdram_writer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_i             (start_i),
    .base_addr_i         (base_addr_i),
    .length_i            (length_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .st_data_i           (st_data_i),
    .st_valid_i          (st_valid_i),
    .st_ready_o          (st_ready_o),
    .sdram_address_o     (sdram_address_o),
    .sdram_burstcount_o  (sdram_burstcount_o),
    .sdram_writedata_o   (sdram_writedata_o),
    .sdram_byteenable_o  (sdram_byteenable_o),
    .sdram_write_o       (sdram_write_o),
    .sdram_waitrequest_i (sdram_waitrequest_i)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input int tag, input int idx);
    return {16'hDA7A, 16'(tag), 32'(idx)};
  endfunction

  function automatic logic [63:0] ctl_vec();
    return {15'd0, busy_o, done_o, st_ready_o, sdram_write_o,
            sdram_address_o, sdram_burstcount_o, sdram_byteenable_o};
  endfunction

  task automatic run_xfer(input int tag, input logic [AW-1:0] base, input int len,
                          input bit rnd, input int abort_at);
    int sent = 0, got = 0, writes = 0, done_cyc = 0, cyc = 0, k, exp_bc;
    bit fin = 1'b0, prev_stall = 1'b0;
    logic [63:0] pdata = 64'd0;
    logic [AW-1:0] paddr = '0, exp_addr;
    logic [7:0] pbc = 8'd0;

    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = base;
    length_i    = 24'(len);
    st_valid_i  = 1'b1;
    st_data_i   = word(tag, 0);
    sdram_waitrequest_i = 1'b0;

    while (!fin && cyc < 3000) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (abort_at > 0 && got == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_ctl_zero", ctl_vec(), 64'd0);
        check_val("abort_wdata_zero", sdram_writedata_o, 64'd0);
        rst = 1'b0;
        st_valid_i = 1'b0;
        sdram_waitrequest_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val("abort_no_done", {63'd0, done_o}, 64'd0);
        end
        return;
      end
      st_data_i  = word(tag, sent);
      st_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sdram_waitrequest_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;

      @(negedge clk);
      cyc++;
      if (sdram_write_o) writes++;
      if (prev_stall) begin
        check_val("stall_write", {63'd0, sdram_write_o}, 64'd1);
        check_val("stall_addr", 64'(sdram_address_o), 64'(paddr));
        check_val("stall_bc", 64'(sdram_burstcount_o), 64'(pbc));
        check_val("stall_data", sdram_writedata_o, pdata);
      end
      if (sdram_write_o && !sdram_waitrequest_i) begin
        k        = got / 16;
        exp_bc   = (len - 16 * k < 16) ? len - 16 * k : 16;
        exp_addr = base + AW'(16 * k);
        check_val("beat_addr", 64'(sdram_address_o), 64'(exp_addr));
        check_val("beat_bc", 64'(sdram_burstcount_o), 64'(exp_bc));
        check_val("beat_data", sdram_writedata_o, word(tag, got));
        check_val("beat_be", 64'(sdram_byteenable_o), 64'hFF);
        got++;
      end
      prev_stall = sdram_write_o & sdram_waitrequest_i;
      paddr = sdram_address_o;
      pbc   = sdram_burstcount_o;
      pdata = sdram_writedata_o;
      if (st_valid_i && st_ready_o) sent++;
      if (done_o) begin
        fin      = 1'b1;
        done_cyc = cyc;
        check_val("done_busy_low", {62'd0, busy_o, st_ready_o}, 64'd0);
        check_val("done_write_low", {63'd0, sdram_write_o}, 64'd0);
      end
    end

    check_val("xfer_finished", {63'd0, fin}, 64'd1);
    @(posedge clk); #1;
    st_valid_i = 1'b0;
    sdram_waitrequest_i = 1'b0;
    @(negedge clk);
    check_val("done_one_cycle", {63'd0, done_o}, 64'd0);
    check_val("beats_total", 64'(got), 64'(len));
    check_val("words_taken", 64'(sent), 64'(len));
    if (len == 0) begin
      check_val("zero_len_no_write", 64'(writes), 64'd0);
      check_val("zero_len_done_lat", 64'(done_cyc), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    length_i = 24'd0;
    st_data_i = 64'd0;
    st_valid_i = 1'b0;
    sdram_waitrequest_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_ctl_zero", ctl_vec(), 64'd0);
    check_val("reset_wdata_zero", sdram_writedata_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_reset_ctl_zero", ctl_vec(), 64'd0);

    run_xfer(1, 29'h100, 32, 1'b0, 0);
    run_xfer(2, 29'h240, 20, 1'b0, 0);
    run_xfer(3, 29'h400, 40, 1'b1, 0);
    run_xfer(4, 29'h555, 0, 1'b0, 0);
    run_xfer(5, 29'h1FFFFFF8, 32, 1'b0, 0);
    run_xfer(6, 29'h800, 32, 1'b0, 5);
    run_xfer(7, 29'h900, 20, 1'b0, 0);
    run_xfer(8, 29'hA00, 7, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
